// File: rtl/mem_ctrl_pkg.sv
// Purpose: shared codes for the byte-wide memory controller (sizes, FSM states, owners).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_ctrl_pkg;

  // Access size codes as presented on ls_size; 2'b11 is handled as a word.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'b00,
    MC_READ  = 2'b01,
    MC_WRITE = 2'b10
  } mc_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } mc_owner_t;

endpackage

// File: rtl/mem_ctrl.sv
// Purpose: arbitrate IF and load/store onto one 8-bit RAM port, split accesses into byte beats.
// Latency: N-byte access done pulse N edges after accept (word fetch: 4 edges), plus stalled edges.
// Backpressure: requesters hold req until done; rdy_in low freezes all state; done cycle accepts nothing.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              ls_req,
  input  logic              ls_wr,
  input  logic [1:0]        ls_size,
  input  logic              ls_signed,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_done,
  output logic [31:0]       ls_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  input  logic [7:0]        mem_din
);

  mc_state_t         state, state_nx;
  mc_owner_t         owner, owner_nx;
  logic [1:0]        size, size_nx;
  logic              sgn, sgn_nx;
  logic [ADDR_W-1:0] base, base_nx;
  logic [31:0]       wdata, wdata_nx;
  logic [31:0]       rbuf, rbuf_nx;
  logic [1:0]        cnt, cnt_nx;
  logic [ADDR_W-1:0] mem_a_nx;
  logic [7:0]        mem_dout_nx;
  logic              mem_wr_nx;
  logic              if_done_nx, ls_done_nx;
  logic [31:0]       if_data_nx, ls_rdata_nx;

  logic [1:0]        last_beat;
  logic [1:0]        cnt_inc;
  logic [31:0]       asm_w;
  logic [31:0]       ext_w;

  // Index of the final beat for the latched size, and the captured word including this edge's byte.
  always_comb begin
    last_beat = 2'd3;
    if (size == SZ_BYTE) last_beat = 2'd0;
    else if (size == SZ_HALF) last_beat = 2'd1;
    cnt_inc = cnt + 2'd1;
    asm_w = rbuf;
    asm_w[{cnt, 3'b000} +: 8] = mem_din;
    ext_w = asm_w;
    case (size)
      SZ_BYTE: ext_w = sgn ? {{24{asm_w[7]}}, asm_w[7:0]} : {24'h0, asm_w[7:0]};
      SZ_HALF: ext_w = sgn ? {{16{asm_w[15]}}, asm_w[15:0]} : {16'h0, asm_w[15:0]};
      default: ext_w = asm_w;
    endcase
  end

  // Next-state and next-output logic; every register holds unless a branch below moves it.
  always_comb begin
    state_nx    = state;
    owner_nx    = owner;
    size_nx     = size;
    sgn_nx      = sgn;
    base_nx     = base;
    wdata_nx    = wdata;
    rbuf_nx     = rbuf;
    cnt_nx      = cnt;
    mem_a_nx    = mem_a;
    mem_dout_nx = mem_dout;
    mem_wr_nx   = mem_wr;
    if_done_nx  = 1'b0;
    ls_done_nx  = 1'b0;
    if_data_nx  = if_data;
    ls_rdata_nx = ls_rdata;

    case (state)
      MC_IDLE: begin
        // The done cycle is dead so a requester can drop req before being re-accepted.
        if (!if_done && !ls_done) begin
          if (ls_req) begin
            state_nx    = ls_wr ? MC_WRITE : MC_READ;
            owner_nx    = OWN_LS;
            size_nx     = ls_size;
            sgn_nx      = ls_signed;
            base_nx     = ls_addr;
            wdata_nx    = ls_wdata;
            rbuf_nx     = ZeroWord;
            cnt_nx      = 2'd0;
            mem_a_nx    = ls_addr;
            mem_dout_nx = ls_wr ? ls_wdata[7:0] : 8'h00;
            mem_wr_nx   = ls_wr;
          end else if (if_req && !if_flush) begin
            state_nx    = MC_READ;
            owner_nx    = OWN_IF;
            size_nx     = SZ_WORD;
            sgn_nx      = 1'b0;
            base_nx     = if_addr;
            wdata_nx    = ZeroWord;
            rbuf_nx     = ZeroWord;
            cnt_nx      = 2'd0;
            mem_a_nx    = if_addr;
            mem_dout_nx = 8'h00;
            mem_wr_nx   = 1'b0;
          end
        end
      end
      MC_READ: begin
        if (owner == OWN_IF && if_flush) begin
          state_nx = MC_IDLE;
          cnt_nx   = 2'd0;
          rbuf_nx  = ZeroWord;
        end else if (cnt == last_beat) begin
          state_nx = MC_IDLE;
          cnt_nx   = 2'd0;
          rbuf_nx  = ZeroWord;
          if (owner == OWN_IF) begin
            if_done_nx = 1'b1;
            if_data_nx = asm_w;
          end else begin
            ls_done_nx  = 1'b1;
            ls_rdata_nx = ext_w;
          end
        end else begin
          rbuf_nx  = asm_w;
          cnt_nx   = cnt_inc;
          mem_a_nx = base + ADDR_W'(cnt_inc);
        end
      end
      MC_WRITE: begin
        if (cnt == last_beat) begin
          state_nx    = MC_IDLE;
          cnt_nx      = 2'd0;
          mem_wr_nx   = 1'b0;
          mem_dout_nx = 8'h00;
          ls_done_nx  = 1'b1;
        end else begin
          cnt_nx      = cnt_inc;
          mem_a_nx    = base + ADDR_W'(cnt_inc);
          mem_dout_nx = wdata[{cnt_inc, 3'b000} +: 8];
        end
      end
      default: state_nx = MC_IDLE;
    endcase
  end

  // State and output registers: reset wins, then rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state    <= MC_IDLE;
      owner    <= OWN_IF;
      size     <= SZ_BYTE;
      sgn      <= 1'b0;
      base     <= '0;
      wdata    <= ZeroWord;
      rbuf     <= ZeroWord;
      cnt      <= 2'd0;
      mem_a    <= '0;
      mem_dout <= 8'h00;
      mem_wr   <= 1'b0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= ZeroWord;
      ls_rdata <= ZeroWord;
    end else if (rdy_in) begin
      state    <= state_nx;
      owner    <= owner_nx;
      size     <= size_nx;
      sgn      <= sgn_nx;
      base     <= base_nx;
      wdata    <= wdata_nx;
      rbuf     <= rbuf_nx;
      cnt      <= cnt_nx;
      mem_a    <= mem_a_nx;
      mem_dout <= mem_dout_nx;
      mem_wr   <= mem_wr_nx;
      if_done  <= if_done_nx;
      ls_done  <= ls_done_nx;
      if_data  <= if_data_nx;
      ls_rdata <= ls_rdata_nx;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Purpose: directed self-checking bench for mem_ctrl against a byte RAM model.
// Latency: checks done timing in negedges counted from the request edge.
// Backpressure: exercises rdy_in stalls, dead done cycle, IF/LS contention.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        ls_req, ls_wr, ls_signed, ls_done;
  logic [1:0]  ls_size;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout, mem_din;
  logic        mem_wr;

  logic [7:0]  ram [0:65535];
  logic        tb_we;
  logic [15:0] tb_wa;
  logic [7:0]  tb_wd;

  int n_chk = 0;
  int n_fail = 0;
  int both_done = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .ls_req(ls_req), .ls_wr(ls_wr), .ls_size(ls_size), .ls_signed(ls_signed),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din)
  );

  // Asynchronous-read RAM: the byte at mem_a is ready before the next edge.
  assign mem_din = ram[mem_a[15:0]];

  // Single write port: bench preload has priority over DUT stores.
  always @(posedge clk_in) begin
    if (tb_we) ram[tb_wa] <= tb_wd;
    else if (mem_wr) ram[mem_a[15:0]] <= mem_dout;
  end

  // Both done pulses high together is always an error.
  always @(negedge clk_in) if (if_done && ls_done) both_done++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(negedge clk_in);
    tb_we = 1'b0;
  endtask

  task automatic start_ls(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] a, input logic [31:0] wd);
    ls_wr = wr; ls_size = sz; ls_signed = sg; ls_addr = a; ls_wdata = wd; ls_req = 1'b1;
  endtask

  // Counts negedges until the chosen done pulse; k = -1 if it never arrives.
  task automatic wait_done(input bit want_ls, output int k, output bit saw_other);
    saw_other = 1'b0;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_in);
      if (want_ls ? if_done : ls_done) saw_other = 1'b1;
      if (want_ls ? ls_done : if_done) begin
        k = i;
        break;
      end
    end
  endtask

  initial begin
    int k;
    bit so;
    int dones;
    rst_in = 1'b0; rdy_in = 1'b1;
    if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_wr = 1'b0; ls_size = 2'b00; ls_signed = 1'b0;
    ls_addr = '0; ls_wdata = '0;
    tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    repeat (2) @(negedge clk_in);
    poke(16'h0100, 8'h11); poke(16'h0101, 8'h22); poke(16'h0102, 8'h33); poke(16'h0103, 8'h44);
    poke(16'h0200, 8'hA1); poke(16'h0201, 8'hB2); poke(16'h0202, 8'hC3); poke(16'h0203, 8'hD4);
    poke(16'h2003, 8'h80); poke(16'h2010, 8'h34); poke(16'h2011, 8'h92);
    poke(16'h2020, 8'h01); poke(16'h2021, 8'h02); poke(16'h2022, 8'h03); poke(16'h2023, 8'h04);
    poke(16'h3002, 8'h5A);

    chk("rst_mem_a", mem_a, 32'h0);
    chk("rst_mem_wr", {31'h0, mem_wr}, 32'h0);
    chk("rst_mem_dout", {24'h0, mem_dout}, 32'h0);
    chk("rst_dones", {30'h0, if_done, ls_done}, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    rst_in = 1'b1;
    @(negedge clk_in);

    // Word fetch
    if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk_in);
    chk("fetch_beat0_a", mem_a, 32'h100);
    chk("fetch_beat0_wr", {31'h0, mem_wr}, 32'h0);
    chk("fetch_beat0_dout", {24'h0, mem_dout}, 32'h0);
    wait_done(1'b0, k, so);
    chk("fetch_lat", k, 4);
    chk("fetch_data", if_data, 32'h44332211);
    if_req = 1'b0;
    @(negedge clk_in);
    chk("fetch_pulse_1cyc", {31'h0, if_done}, 32'h0);

    // Byte loads, signed then unsigned
    start_ls(1'b0, 2'b00, 1'b1, 32'h2003, 32'h0);
    wait_done(1'b1, k, so);
    chk("lb_lat", k, 2);
    chk("lb_signed", ls_rdata, 32'hFFFFFF80);
    ls_req = 1'b0;
    @(negedge clk_in);
    start_ls(1'b0, 2'b00, 1'b0, 32'h2003, 32'h0);
    wait_done(1'b1, k, so);
    chk("lbu", ls_rdata, 32'h00000080);
    ls_req = 1'b0;
    @(negedge clk_in);

    // Signed half and illegal size 11 as word
    start_ls(1'b0, 2'b01, 1'b1, 32'h2010, 32'h0);
    wait_done(1'b1, k, so);
    chk("lh_lat", k, 3);
    chk("lh_signed", ls_rdata, 32'hFFFF9234);
    ls_req = 1'b0;
    @(negedge clk_in);
    start_ls(1'b0, 2'b11, 1'b1, 32'h2020, 32'h0);
    wait_done(1'b1, k, so);
    chk("lw11_lat", k, 5);
    chk("lw11_data", ls_rdata, 32'h04030201);
    ls_req = 1'b0;
    @(negedge clk_in);

    // Store half
    start_ls(1'b1, 2'b01, 1'b0, 32'h3000, 32'hDEADBEEF);
    @(negedge clk_in);
    chk("sh_b0", {mem_a[15:0], mem_dout, 7'h0, mem_wr}, {16'h3000, 8'hEF, 8'h01});
    @(negedge clk_in);
    chk("sh_b1", {mem_a[15:0], mem_dout, 7'h0, mem_wr}, {16'h3001, 8'hBE, 8'h01});
    @(negedge clk_in);
    chk("sh_done", {30'h0, mem_wr, ls_done}, 32'h1);
    ls_req = 1'b0;
    @(negedge clk_in);
    chk("sh_ram", {8'h0, ram[16'h3002], ram[16'h3001], ram[16'h3000]}, 32'h005ABEEF);

    // Simultaneous requests: LS first, IF after the dead done cycle
    if_req = 1'b1; if_addr = 32'h100;
    start_ls(1'b0, 2'b00, 1'b0, 32'h2003, 32'h0);
    @(negedge clk_in);
    chk("cont_ls_first", mem_a, 32'h2003);
    @(negedge clk_in);
    chk("cont_ls_done", {30'h0, if_done, ls_done}, 32'h1);
    ls_req = 1'b0;
    @(negedge clk_in);
    chk("cont_dead_cycle", mem_a, 32'h2003);
    @(negedge clk_in);
    chk("cont_if_accept", mem_a, 32'h100);
    wait_done(1'b0, k, so);
    chk("cont_if_lat", k, 4);
    chk("cont_if_data", if_data, 32'h44332211);
    if_req = 1'b0;
    @(negedge clk_in);

    // IF raised mid-LS: no preemption
    start_ls(1'b0, 2'b10, 1'b0, 32'h2020, 32'h0);
    @(negedge clk_in);
    if_req = 1'b1; if_addr = 32'h200;
    wait_done(1'b1, k, so);
    chk("nopre_ls_lat", k, 4);
    chk("nopre_no_if", {31'h0, so}, 32'h0);
    chk("nopre_ls_data", ls_rdata, 32'h04030201);
    ls_req = 1'b0;
    wait_done(1'b0, k, so);
    chk("nopre_if_lat", k, 6);
    chk("nopre_if_data", if_data, 32'hD4C3B2A1);
    if_req = 1'b0;
    @(negedge clk_in);

    // Flush at beat 2, then a fresh fetch
    if_req = 1'b1; if_addr = 32'h100;
    repeat (3) @(negedge clk_in);
    chk("flush_at_beat2", mem_a, 32'h102);
    if_flush = 1'b1;
    @(negedge clk_in);
    chk("flush_no_done", {31'h0, if_done}, 32'h0);
    if_flush = 1'b0; if_addr = 32'h200;
    @(negedge clk_in);
    chk("flush_refetch_a", mem_a, 32'h200);
    wait_done(1'b0, k, so);
    chk("flush_refetch_lat", k, 4);
    chk("flush_refetch_data", if_data, 32'hD4C3B2A1);
    if_req = 1'b0;
    @(negedge clk_in);

    // if_req ignored while if_flush high in IDLE
    if_req = 1'b1; if_flush = 1'b1; if_addr = 32'h100;
    repeat (3) @(negedge clk_in);
    chk("idle_flush_ignore", {mem_a[30:0], if_done}, {31'h203, 1'b0});
    if_req = 1'b0; if_flush = 1'b0;
    @(negedge clk_in);

    // Stall mid-store
    start_ls(1'b1, 2'b10, 1'b0, 32'h3010, 32'h11223344);
    @(negedge clk_in);
    chk("stall_b0", {mem_a[15:0], mem_dout, 7'h0, mem_wr}, {16'h3010, 8'h44, 8'h01});
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("stall_hold", {mem_a[15:0], mem_dout, 6'h0, mem_wr, ls_done}, {16'h3010, 8'h44, 8'h02});
    end
    rdy_in = 1'b1;
    wait_done(1'b1, k, so);
    chk("stall_lat", k, 4);
    ls_req = 1'b0;
    @(negedge clk_in);
    chk("stall_ram", {ram[16'h3013], ram[16'h3012], ram[16'h3011], ram[16'h3010]}, 32'h11223344);

    // Reset mid-read
    if_req = 1'b1; if_addr = 32'h100;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0; if_req = 1'b0;
    @(negedge clk_in);
    chk("rstmid_mem", {mem_a[22:0], mem_dout, mem_wr}, 32'h0);
    chk("rstmid_if_data", if_data, 32'h0);
    chk("rstmid_ls_rdata", ls_rdata, 32'h0);
    rst_in = 1'b1;
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      if (if_done || ls_done) dones++;
    end
    chk("rstmid_no_done", dones, 0);
    if_req = 1'b1; if_addr = 32'h200;
    wait_done(1'b0, k, so);
    chk("rstmid_refetch_lat", k, 5);
    chk("rstmid_refetch_data", if_data, 32'hD4C3B2A1);
    if_req = 1'b0;
    @(negedge clk_in);

    chk("dones_exclusive", both_done, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
